ps2_key_fifo: RTL and testbench

- Buffers keyboard events from the HPS-side ps2_key toggle bus so the CPU inside the system block never misses a key.
- Sits between the hps_io ps2_key output and the system block's keyboard read port, in the clk_sys domain.
- Presents queued {pressed, extended, scancode} records first-word-fall-through, with a pop strobe, an occupancy count and a sticky overflow flag.

---
 rtl/ps2_key_fifo.sv | 82 ++++++++
 tb/tb_ps2_key_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_fifo.sv
// Keyboard event queue between the hps_io ps2_key toggle bus and the system CPU.
// A first-word-fall-through FIFO of {pressed, extended, scancode} with count and sticky overflow.
module ps2_key_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic [10:0]   ps2_key,
  input  logic          rd,
  output logic [9:0]    data,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          clr_overflow
);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          armed;
  logic          toggle_q;

  logic          full;
  logic          new_event;
  logic          do_pop;
  logic          do_push;
  logic          drop;
  logic [AW:0]   count_next;

  always_comb begin
    full       = (count == (AW+1)'(DEPTH));
    new_event  = armed && (ps2_key[10] != toggle_q);
    do_pop     = rd && !empty;
    // A pop on the same edge frees a slot, so a full queue still accepts the push.
    do_push    = new_event && (!full || do_pop);
    drop       = new_event && full && !do_pop;
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + (AW+1)'(1);
    else if (do_pop && !do_push)
      count_next = count - (AW+1)'(1);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      armed    <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      // The first edge after reset only captures the current toggle level.
      if (!armed) begin
        armed    <= 1'b1;
        toggle_q <= ps2_key[10];
      end else if (new_event) begin
        toggle_q <= ps2_key[10];
      end
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      empty <= (count_next == '0);
      if (drop)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push)
      mem[wr_ptr] <= ps2_key[9:0];
  end

  assign data = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Scoreboard bench for ps2_key_fifo: a queue-based reference model predicts the pops,
// a negedge monitor compares occupancy, flags and popped records.
module tb_ps2_key_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk_sys;
  logic          reset_n;
  logic [10:0]   ps2_key;
  logic          rd;
  logic [9:0]    data;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          clr_overflow;

  ps2_key_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_key      (ps2_key),
    .rd           (rd),
    .data         (data),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int tests  = 0;
  int failed = 0;

  // Reference model: committed state after the most recent clock edge.
  logic [9:0] exp_q [$];
  int         m_cnt   = 0;
  bit         m_ovf   = 0;
  bit         m_armed = 0;
  bit         m_tq    = 0;
  bit         tog     = 0;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic commit();
    bit t = ps2_key[10];
    bit ev;
    bit dropped = 0;
    if (!m_armed) begin
      m_armed = 1;
      m_tq    = t;
      ev      = 0;
    end else begin
      ev   = (t != m_tq);
      m_tq = t;
    end
    if (rd && m_cnt > 0) m_cnt--;
    if (ev) begin
      if (m_cnt < DEPTH) begin
        m_cnt++;
        exp_q.push_back(ps2_key[9:0]);
      end else begin
        dropped = 1;
      end
    end
    if (dropped) m_ovf = 1;
    else if (clr_overflow) m_ovf = 0;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    if (reset_n) commit();
    #2;
  endtask

  task automatic step(input bit ev, input logic [9:0] rec, input bit r, input bit c);
    tick();
    if (ev) tog = ~tog;
    ps2_key      = {tog, rec};
    rd           = r;
    clr_overflow = c;
  endtask

  task automatic do_reset(input bit new_tog);
    tick();
    reset_n = 1'b0;
    m_cnt = 0; m_ovf = 0; m_armed = 0; m_tq = 0;
    exp_q.delete();
    tog = new_tog;
    ps2_key = {tog, 10'h000};
    rd = 1'b0;
    clr_overflow = 1'b0;
    #1;
    chk("reset_empty", int'(empty), 1);
    chk("reset_count", int'(count), 0);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: compares DUT outputs against the model and pops the scoreboard on reads.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      chk("empty", int'(empty), int'(m_cnt == 0));
      chk("count", int'(count), m_cnt);
      chk("overflow", int'(overflow), int'(m_ovf));
      if (rd && !empty) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL pop_data: got %0h, expected nothing queued at %0t", data, $time);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          $display("[TB] pop data=%03h expected=%03h", data, e);
          chk("pop_data", int'(data), int'(e));
        end
      end
    end
  end

  initial begin
    reset_n      = 1'b0;
    tog          = 1'b1;
    ps2_key      = 11'h400;
    rd           = 1'b0;
    clr_overflow = 1'b0;
    #12 reset_n  = 1'b1;

    // Toggle already high at reset release: no spurious push.
    for (int i = 0; i < 10; i++) begin
      step(0, 10'h000, 0, 0);
      chk("t1_empty", int'(empty), 1);
      chk("t1_count", int'(count), 0);
    end

    // Two events, then two pops.
    do_reset(0);
    step(0, 10'h000, 0, 0);
    step(1, 10'h01C, 0, 0);
    step(1, 10'h31C, 0, 0);
    chk("t2_empty", int'(empty), 0);
    step(0, 10'h31C, 0, 0);
    chk("t2_count", int'(count), 2);
    chk("t2_data", int'(data), 10'h01C);
    step(0, 10'h31C, 1, 0);
    step(0, 10'h31C, 0, 0);
    chk("t2_data2", int'(data), 10'h31C);
    chk("t2_count2", int'(count), 1);
    step(0, 10'h31C, 1, 0);
    step(0, 10'h31C, 0, 0);
    chk("t2_empty2", int'(empty), 1);

    // Fill to DEPTH.
    for (int i = 0; i < DEPTH; i++)
      step(1, {2'($urandom), 8'(i)}, 0, 0);
    step(0, 10'h000, 0, 0);
    chk("t3_full_count", int'(count), DEPTH);
    chk("t3_full_ovf", int'(overflow), 0);

    // Push and pop on the same edge while full.
    step(1, 10'h3AB, 1, 0);
    step(0, 10'h3AB, 0, 0);
    chk("t4_count", int'(count), DEPTH);
    chk("t4_ovf", int'(overflow), 0);

    // Drop while full.
    step(1, 10'h0EE, 0, 0);
    step(0, 10'h0EE, 0, 0);
    chk("t3_ovf", int'(overflow), 1);
    chk("t3_count", int'(count), DEPTH);

    // Clear coincident with a drop keeps overflow set; clear alone clears it.
    step(1, 10'h0DD, 0, 1);
    step(0, 10'h0DD, 0, 0);
    chk("t5_ovf_set_wins", int'(overflow), 1);
    step(0, 10'h0DD, 0, 1);
    step(0, 10'h0DD, 0, 0);
    chk("t5_ovf_clear", int'(overflow), 0);

    // Drain; scoreboard checks order and that dropped records never appear.
    for (int i = 0; i < DEPTH; i++)
      step(0, 10'h000, 1, 0);
    step(0, 10'h000, 0, 0);
    chk("t3_drained", int'(empty), 1);

    // Randomized traffic with alternating read pressure.
    for (int i = 0; i < 1500; i++) begin
      int bias = ((i / 150) % 2 == 1) ? 8 : 2;
      step(bit'($urandom_range(0, 1)), 10'($urandom),
           bit'($urandom_range(0, 9) < bias), bit'($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++)
      step(0, 10'h000, 1, 0);

    // Asynchronous reset mid-stream with three entries queued.
    for (int i = 0; i < 3; i++)
      step(1, 10'($urandom), 0, 0);
    step(0, 10'h000, 0, 0);
    chk("t6_count3", int'(count), 3);
    do_reset(~tog);
    step(0, 10'h000, 0, 0);
    chk("t6_arm_count", int'(count), 0);
    chk("t6_arm_empty", int'(empty), 1);
    step(1, 10'h15A, 0, 0);
    step(0, 10'h15A, 0, 0);
    chk("t6_count1", int'(count), 1);
    step(0, 10'h15A, 1, 0);
    step(0, 10'h15A, 0, 0);
    step(0, 10'h15A, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
